// File: rtl/aes_cbc_enc_ctrl_if.sv
// Stream and cipher-core bus for aes_cbc_enc_ctrl.
//   in_*       : plaintext valid/ready stream into the controller
//   out_*      : ciphertext valid/ready stream out of the controller
//   core_*     : load/done handshake with the AES-128 cipher core
// modport master : controller view (drives in_ready, out_*, core_ld/key/text_in)
// modport slave  : environment view (source, sink and cipher core)
interface aes_cbc_enc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic         core_done;
  logic [127:0] core_text_out;

  modport master (
    input  in_valid, in_data, in_last, out_ready, core_done, core_text_out,
    output in_ready, out_valid, out_data, out_last, core_ld, core_key, core_text_in
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready, core_done, core_text_out,
    input  in_ready, out_valid, out_data, out_last, core_ld, core_key, core_text_in
  );
endinterface

// File: rtl/aes_cbc_enc_ctrl.sv
// aes_cbc_enc_ctrl: CBC-mode encryption sequencer around an AES-128 core.
// Takes plaintext blocks, XORs each with the chaining value (IV or previous
// ciphertext), loads the core, captures its result on core_done and offers
// it downstream. One block in flight at a time.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cfg_load       : load cfg_key/cfg_iv (honoured only while idle)
//   cfg_key/cfg_iv : AES-128 key and initialisation vector
//   busy           : high whenever the sequencer is not idle
//   err            : sticky WAIT timeout flag (0 unless timeout enabled)
//   bus            : in/out streams and cipher-core handshake (master view)
// Build option: define AES_CBC_TIMEOUT_EN to abort a block that waits more
// than TIMEOUT_CYC cycles for core_done.
module aes_cbc_enc_ctrl #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [127:0]         cfg_key,
  input  logic [127:0]         cfg_iv,
  output logic                 busy,
  output logic                 err,
  aes_cbc_enc_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_r, iv_r, chain, txt_r, out_data_r;
  logic         last_r, out_last_r, core_ld_r;
  logic         in_ready;
  logic         timeout;

  // cfg_load wins over a same-cycle plaintext block.
  assign in_ready         = (state == IDLE) && !cfg_load;
  assign busy             = (state != IDLE);
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state == OUT);
  assign bus.out_data     = out_data_r;
  assign bus.out_last     = out_last_r;
  assign bus.core_ld      = core_ld_r;
  assign bus.core_key     = key_r;
  assign bus.core_text_in = txt_r;

`ifdef AES_CBC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_r;

  // Fires on the TIMEOUT_CYC-th WAIT cycle without done; done has priority.
  assign timeout = (state == WAIT) && !bus.core_done &&
                   (wait_cnt == CW'(TIMEOUT_CYC - 1));
  assign err     = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_r    <= 1'b0;
    end else if (state == LOAD) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !bus.core_done) begin
      if (timeout) err_r    <= 1'b1;
      else         wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid && in_ready) state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: begin
        if (bus.core_done) state_nxt = OUT;
        else if (timeout)  state_nxt = IDLE;
      end
      OUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_r      <= '0;
      iv_r       <= '0;
      chain      <= '0;
      txt_r      <= '0;
      last_r     <= 1'b0;
      core_ld_r  <= 1'b0;
      out_data_r <= '0;
      out_last_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            key_r <= cfg_key;
            iv_r  <= cfg_iv;
            chain <= cfg_iv;
          end else if (bus.in_valid) begin
            txt_r     <= bus.in_data ^ chain;
            last_r    <= bus.in_last;
            core_ld_r <= 1'b1;
          end
        end
        LOAD: core_ld_r <= 1'b0;
        WAIT: begin
          if (bus.core_done) begin
            out_data_r <= bus.core_text_out;
            out_last_r <= last_r;
            // After the last block the next message restarts from the IV.
            chain      <= last_r ? iv_r : bus.core_text_out;
          end else if (timeout) begin
            chain <= iv_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_enc_ctrl.sv
// Directed bench for aes_cbc_enc_ctrl with a behavioural cipher-core model.
// The core model returns the published AES-128 results for the known test
// vectors and ~(text ^ key) for anything else.
module tb_aes_cbc_enc_ctrl;
  localparam int TMO      = 15;
  localparam int CORE_LAT = 12;

  localparam logic [127:0] NIST_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIST_IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NIST_P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] NIST_P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] NIST_X1 = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] NIST_X2 = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] NIST_C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] NIST_C2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2      = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] IV2     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2      = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_load = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         busy, err;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           done_en = 1'b1;
  int           done_cnt = 0;
  int           m_cnt = 0;
  logic [127:0] m_key, m_txt;

  aes_cbc_enc_ctrl_if bus ();

  aes_cbc_enc_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_load (cfg_load),
    .cfg_key  (cfg_key),
    .cfg_iv   (cfg_iv),
    .busy     (busy),
    .err      (err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] t);
    if (k == NIST_K && t == NIST_X1) return NIST_C1;
    if (k == NIST_K && t == NIST_X2) return NIST_C2;
    if (k == FIPS_K && t == FIPS_P)  return FIPS_C;
    return ~(t ^ k);
  endfunction

  // Cipher core model: done pulses CORE_LAT cycles after ld is sampled.
  always @(posedge clk) begin
    bus.core_done     <= 1'b0;
    bus.core_text_out <= {4{$urandom}};
    if (bus.core_ld) begin
      m_cnt <= 1;
      m_key <= bus.core_key;
      m_txt <= bus.core_text_in;
    end else if (m_cnt != 0) begin
      if (m_cnt == CORE_LAT) begin
        m_cnt <= 0;
        if (done_en) begin
          bus.core_done     <= 1'b1;
          bus.core_text_out <= aes_ref(m_key, m_txt);
          done_cnt          <= done_cnt + 1;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [127:0] k, input logic [127:0] iv);
    cfg_load = 1'b1;
    cfg_key  = k;
    cfg_iv   = iv;
    tick();
    cfg_load = 1'b0;
    #1;
  endtask

  // Returns one cycle after the input handshake edge (LOAD state).
  task automatic send(input logic [127:0] d, input logic l);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
    while (!bus.in_ready && k < 100) begin
      tick();
      k++;
    end
    chk("send_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [127:0] d, input logic l);
    int k = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && k < 100) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_data"}, bus.out_data, d);
    chk({tag, "_last"}, bus.out_last, l);
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int bad;
    int dc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_core_ld", bus.core_ld, 1'b0);
    chk("rst_core_key", bus.core_key, '0);
    chk("rst_core_text", bus.core_text_in, '0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // NIST SP800-38A CBC, two blocks
    cfg(NIST_K, NIST_IV);
    send(NIST_P1, 1'b0);
    chk("nist_ld_hi", bus.core_ld, 1'b1);
    chk("nist_x1", bus.core_text_in, NIST_X1);
    chk("nist_key", bus.core_key, NIST_K);
    chk("nist_busy", busy, 1'b1);
    chk("nist_in_ready_lo", bus.in_ready, 1'b0);
    tick();
    chk("nist_ld_lo", bus.core_ld, 1'b0);
    recv("nist_c1", NIST_C1, 1'b0);
    send(NIST_P2, 1'b1);
    chk("nist_x2", bus.core_text_in, NIST_X2);
    recv("nist_c2", NIST_C2, 1'b1);

    // FIPS-197 single block, then the same block again
    cfg(FIPS_K, '0);
    send(FIPS_P, 1'b1);
    recv("fips_a", FIPS_C, 1'b1);
    send(FIPS_P, 1'b1);
    chk("fips_resend_txt", bus.core_text_in, FIPS_P);
    recv("fips_b", FIPS_C, 1'b1);

    // Backpressure: hold out_ready low for 20 cycles
    send(FIPS_P, 1'b1);
    dc = 0;
    while (!bus.out_valid && dc < 100) begin
      tick();
      dc++;
    end
    chk("bp_valid", bus.out_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== FIPS_C || bus.in_ready !== 1'b0 ||
          busy !== 1'b1)
        bad++;
    end
    chk("bp_stable_cycles_bad", bad, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_valid", bus.out_valid, 1'b0);

    // cfg_load and in_valid together: cfg wins, block goes next cycle
    cfg_load     = 1'b1;
    cfg_key      = K2;
    cfg_iv       = IV2;
    bus.in_valid = 1'b1;
    bus.in_data  = P2;
    bus.in_last  = 1'b1;
    #1;
    chk("sim_in_ready_lo", bus.in_ready, 1'b0);
    tick();
    cfg_load = 1'b0;
    #1;
    chk("sim_in_ready_hi", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("sim_ld", bus.core_ld, 1'b1);
    chk("sim_txt", bus.core_text_in, {128{1'b1}});
    chk("sim_key", bus.core_key, K2);
    recv("sim_out", K2, 1'b1);

    // Reset mid-WAIT, stale done afterwards must be ignored
    cfg(FIPS_K, '0);
    dc = done_cnt;
    send(FIPS_P, 1'b1);
    tick(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_out_data", bus.out_data, '0);
    chk("mrst_core_ld", bus.core_ld, 1'b0);
    chk("mrst_core_key", bus.core_key, '0);
    chk("mrst_core_text", bus.core_text_in, '0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mrst_stale_done_seen", done_cnt - dc, 1);
    chk("mrst_no_output_bad", bad, 0);

`ifdef AES_CBC_TIMEOUT_EN
    // Core never answers: abort after TMO WAIT cycles
    cfg(FIPS_K, '0);
    done_en = 1'b0;
    send(FIPS_P, 1'b1);
    tick(TMO);
    chk("tmo_err_early", err, 1'b0);
    chk("tmo_busy_early", busy, 1'b1);
    tick();
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_in_ready", bus.in_ready, 1'b1);
    chk("tmo_out_valid", bus.out_valid, 1'b0);
    done_en = 1'b1;
    tick(5);
    send(FIPS_P, 1'b1);
    recv("tmo_after", FIPS_C, 1'b1);
    chk("tmo_err_sticky", err, 1'b1);
    do_reset();
    tick();
    chk("tmo_err_cleared", err, 1'b0);
`else
    // Core never answers: controller keeps waiting, err stays low
    cfg(FIPS_K, '0);
    done_en = 1'b0;
    send(FIPS_P, 1'b1);
    tick(40);
    chk("hang_busy", busy, 1'b1);
    chk("hang_err", err, 1'b0);
    chk("hang_out_valid", bus.out_valid, 1'b0);
    done_en = 1'b1;
    do_reset();
    tick();
    chk("hang_rst_busy", busy, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_cbc_enc_ctrl.md
Name: aes_cbc_enc_ctrl

Overview:
- Upstream/downstream sequencer wrapped around the AES-128 cipher core; it drives the core's `ld`/`key`/`text_in` and consumes its `done`/`text_out`.
- Accepts plaintext blocks on a valid/ready stream and XORs each with the CBC chaining value (IV or previous ciphertext).
- Issues one core load per block, captures the ciphertext on `done`, and presents it on a valid/ready output stream.
- Provides CBC-mode encryption over a message of one or more 128-bit blocks.

Parameters:
- TIMEOUT_CYC, 15, maximum cycles spent in WAIT before an error abort. Used only with AES_CBC_TIMEOUT_EN. Core nominal latency is about 12 cycles.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- cfg_load  in  1  load key and IV (accepted only in IDLE)
- cfg_key  in  128  AES-128 key
- cfg_iv  in  128  initialisation vector
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  plaintext block valid
- in_ready  out  1  plaintext block accepted when in_valid&in_ready
- in_data  in  128  plaintext block, byte 0 in [127:120]
- in_last  in  1  marks the last block of a message
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  128  ciphertext block
- out_last  out  1  copy of in_last for this block
- core_ld  out  1  one-cycle load strobe to cipher core
- core_key  out  128  key to core; equals key_r
- core_text_in  out  128  core input; registered in_data^chain
- core_done  in  1  cipher core completion pulse
- core_text_out  in  128  cipher core result; valid while core_done=1
- err  out  1  sticky timeout flag

Behaviour:
- Registers: key_r, iv_r, chain, txt_r, out_data, out_last, last_r, core_ld, state, wait_cnt.
- Reset (rst=1 at an edge): state=IDLE; core_ld=0; out_valid=0; out_last=0; err=0; out_data=0; key_r=iv_r=chain=txt_r=0.
- Reset mid-operation aborts the block. A later core_done is ignored because the FSM is not in WAIT.
- States: IDLE, LOAD, WAIT, OUT. busy = (state!=IDLE).
- IDLE:
  - cfg_load=1 -> key_r<=cfg_key, iv_r<=cfg_iv, chain<=cfg_iv. Stay in IDLE.
  - in_ready = (state==IDLE) & !cfg_load. cfg_load has priority over in_valid in the same cycle.
  - in_valid&in_ready -> txt_r<=in_data^chain, last_r<=in_last, core_ld<=1, go to LOAD.
- LOAD: lasts exactly one cycle with core_ld=1. Next edge: core_ld<=0, wait_cnt<=0, go to WAIT.
- WAIT:
  - core_done=1 -> out_data<=core_text_out, out_last<=last_r, go to OUT.
  - chain<=core_text_out when last_r=0; chain<=iv_r when last_r=1 (next message restarts from IV).
  - core_done outside WAIT is ignored.
- OUT: out_valid=1; out_data/out_last held stable. out_valid&out_ready -> go to IDLE. out_valid low in all other states.
- Throughput: one block in flight. Next block is accepted no earlier than the cycle after output handshake.
- Latency from input handshake edge T:
  - core_ld high during cycle T+1.
  - out_valid rises one cycle after the cycle in which core_done is sampled high.
- cfg_load outside IDLE: ignored, no side effects.
- core_key=key_r at all times; stable across every core_ld.
- core_text_in=txt_r; stable from LOAD until the next accepted block.

Optional Feature:
- Macro AES_CBC_TIMEOUT_EN.
- When defined:
  - wait_cnt increments every WAIT cycle without core_done.
  - On reaching TIMEOUT_CYC: err<=1, chain<=iv_r, state<=IDLE, no output produced.
  - err is sticky until rst.
  - core_done and the timeout in the same cycle: core_done wins.
- When undefined: no counter; WAIT waits indefinitely; err is tied to 0.

Test Plan:
- NIST SP800-38A CBC vector:
  - cfg_key=2b7e151628aed2a6abf7158809cf4f3c, cfg_iv=000102030405060708090a0b0c0d0e0f.
  - Blocks 6bc1bee22e409f96e93d7e117393172a, then ae2d8a571e03ac9c9eb76fac45af8e51 (last).
  - Expect out_data 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2 with out_last=1.
- FIPS-197 ECB-equivalent:
  - key 000102030405060708090a0b0c0d0e0f, iv=0, in 00112233445566778899aabbccddeeff, in_last=1.
  - Expect out 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Resend the same block: identical output (chain restored to IV).
- Backpressure: out_ready held 0 for 20 cycles after out_valid.
  - out_valid/out_data stay stable, in_ready=0, busy=1.
  - When out_ready=1: handshake, then IDLE next cycle.
- Simultaneous cfg_load=1 and in_valid=1 in IDLE: in_ready=0; new key/IV taken; block accepted next cycle and encrypted under the new IV.
- Reset mid-WAIT: assert rst 5 cycles after core_ld.
  - All outputs at reset values.
  - Stale core_done 7 cycles later produces no out_valid.
- With AES_CBC_TIMEOUT_EN and a core model that never asserts done: err=1 exactly TIMEOUT_CYC cycles after entering WAIT; state IDLE; in_ready=1.
